// File: rtl/strobe_gen.sv
// Triggered strobe generator: after an accepted trigger, waits D cycles, then drives o_strobe for W cycles.
// Optional output polarity select is built when macro STROBE_INVERT_EN is defined.
module strobe_gen #(
    parameter int STROBE_CNT_WIDTH = 19
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_strobe_en,
    input  logic                        i_trigger,
    input  logic [STROBE_CNT_WIDTH-1:0] iv_strobe_delay,
    input  logic [STROBE_CNT_WIDTH-1:0] iv_strobe_width,
`ifdef STROBE_INVERT_EN
    input  logic                        i_strobe_invert,
`endif
    output logic                        o_strobe,
    output logic                        o_busy,
    output logic                        o_overrun
);

    localparam logic [STROBE_CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [STROBE_CNT_WIDTH-1:0] CNT_ONE  = {{(STROBE_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [STROBE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [STROBE_CNT_WIDTH-1:0]   delay_q, delay_d;
    logic [STROBE_CNT_WIDTH-1:0]   width_q, width_d;
    logic                          strobe_q, strobe_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;
    logic [1:0]                    rst_sync_q, rst_sync_d;
    logic                          inv_level;
    logic                          ready;

`ifdef STROBE_INVERT_EN
    assign inv_level = i_strobe_invert;
`else
    assign inv_level = 1'b0;
`endif

    // Triggers are only honoured once the reset release has passed through two flops.
    assign ready = rst_sync_q[1];

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        width_d    = width_q;
        overrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_trigger && i_strobe_en && ready) begin
                    delay_d = iv_strobe_delay;
                    width_d = iv_strobe_width;
                    cnt_d   = CNT_ZERO;
                    if (iv_strobe_width != CNT_ZERO) begin
                        state_d = (iv_strobe_delay == CNT_ZERO) ? ACTIVE : DELAY;
                    end
                end
            end
            DELAY: begin
                if (!i_strobe_en) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == delay_q - CNT_ONE) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ACTIVE: begin
                if (!i_strobe_en || (cnt_q == width_q - CNT_ONE)) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        if (i_trigger && i_strobe_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are derived from the next state so they line up with it after the edge.
        busy_d   = (state_d != IDLE);
        strobe_d = (state_d == ACTIVE) ^ inv_level;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            delay_q    <= CNT_ZERO;
            width_q    <= CNT_ZERO;
            strobe_q   <= inv_level;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_strobe  = strobe_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Directed testbench for strobe_gen: hand-computed strobe/busy/overrun windows, cycle-numbered
// so that the accepting edge of each sequence is edge 10.
module tb_strobe_gen;

    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          i_strobe_en;
    logic          i_trigger;
    logic [CW-1:0] iv_strobe_delay;
    logic [CW-1:0] iv_strobe_width;
    logic          inv;
    logic          o_strobe;
    logic          o_busy;
    logic          o_overrun;

    int total;
    int bad;

    strobe_gen #(.STROBE_CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_strobe_en     (i_strobe_en),
        .i_trigger       (i_trigger),
        .iv_strobe_delay (iv_strobe_delay),
        .iv_strobe_width (iv_strobe_width),
`ifdef STROBE_INVERT_EN
        .i_strobe_invert (inv),
`endif
        .o_strobe        (o_strobe),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun)
    );

    initial clk = 1'b0;
    always #7 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Trigger at edge 10, then check every cycle 11..last against the given windows.
    task automatic seq(input string name, input int d, input int w,
                       input int s_lo, input int s_hi, input int b_lo, input int b_hi,
                       input int ov, input int t2, input int en_off, input int last);
        logic [CW-1:0] dv;
        logic [CW-1:0] wv;
        dv = CW'(d);
        wv = CW'(w);
        iv_strobe_delay = dv;
        iv_strobe_width = wv;
        i_strobe_en     = 1'b1;
        i_trigger       = 1'b1;
        step();
        i_trigger       = 1'b0;
        iv_strobe_delay = ~dv;
        iv_strobe_width = ~wv;
        for (int cur = 11; cur <= last; cur++) begin
            chk($sformatf("%s strobe c%0d", name, cur), o_strobe,
                logic'((cur >= s_lo) && (cur <= s_hi)) ^ inv);
            chk($sformatf("%s busy c%0d", name, cur), o_busy,
                logic'((cur >= b_lo) && (cur <= b_hi)));
            chk($sformatf("%s overrun c%0d", name, cur), o_overrun, logic'(cur == ov));
            if (cur < last) begin
                i_trigger   = (cur == t2);
                i_strobe_en = !((en_off != 0) && (cur >= en_off));
                step();
            end
        end
        i_trigger       = 1'b0;
        i_strobe_en     = 1'b1;
        iv_strobe_delay = dv;
        iv_strobe_width = wv;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        inv             = 1'b0;
        reset_n         = 1'b0;
        i_strobe_en     = 1'b0;
        i_trigger       = 1'b0;
        iv_strobe_delay = '0;
        iv_strobe_width = '0;
        step();
        step();
        chk("reset strobe", o_strobe, 1'b0);
        chk("reset busy", o_busy, 1'b0);
        chk("reset overrun", o_overrun, 1'b0);
        reset_n     = 1'b1;
        i_strobe_en = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // D=3 W=5; then a trigger at edge 19 must be accepted
        seq("d3w5", 3, 5, 14, 18, 11, 18, 0, 0, 0, 19);
        i_trigger = 1'b1;
        step();
        i_trigger = 1'b0;
        chk("d3w5 retrigger busy", o_busy, 1'b1);
        chk("d3w5 retrigger overrun", o_overrun, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("d3w5 retrigger done", o_busy, 1'b0);
        $display("txn d3w5 done total=%0d", total);

        seq("d0w1", 0, 1, 11, 11, 11, 11, 0, 0, 0, 14);
        $display("txn d0w1 done total=%0d", total);
        seq("d0w0", 0, 0, 0, -1, 0, -1, 0, 0, 0, 14);
        $display("txn d0w0 done total=%0d", total);
        seq("drop", 2, 4, 13, 16, 11, 16, 13, 12, 0, 18);
        $display("txn drop done total=%0d", total);
        seq("abort", 2, 10, 13, 15, 11, 15, 0, 0, 15, 20);
        $display("txn abort done total=%0d", total);
        seq("max", 15, 15, 26, 40, 11, 40, 0, 0, 0, 42);
        $display("txn max done total=%0d", total);

        // Trigger with enable low is ignored silently
        i_strobe_en = 1'b0;
        i_trigger   = 1'b1;
        step();
        i_trigger   = 1'b0;
        i_strobe_en = 1'b1;
        chk("en0 busy", o_busy, 1'b0);
        chk("en0 overrun", o_overrun, 1'b0);
        step();
        chk("en0 busy later", o_busy, 1'b0);
        $display("txn en0 done total=%0d", total);

        // Reset in the middle of ACTIVE (strobe covers cycles 12..19)
        iv_strobe_delay = CW'(1);
        iv_strobe_width = CW'(8);
        i_trigger = 1'b1;
        step();
        i_trigger = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst pre strobe", o_strobe, 1'b1 ^ inv);
        #2 reset_n = 1'b0;
        #1;
        chk("rst async strobe", o_strobe, inv);
        chk("rst async busy", o_busy, 1'b0);
        step();
        step();
        reset_n   = 1'b1;
        i_trigger = 1'b1;
        step();
        i_trigger = 1'b0;
        chk("rst sync first edge busy", o_busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rst after strobe %0d", i), o_strobe, inv);
            chk($sformatf("rst after busy %0d", i), o_busy, 1'b0);
            step();
        end
        i_trigger = 1'b1;
        step();
        i_trigger = 1'b0;
        chk("rst post trigger busy", o_busy, 1'b1);
        for (int i = 0; i < 12; i++) step();
        chk("rst post done", o_busy, 1'b0);
        $display("txn reset done total=%0d", total);

`ifdef STROBE_INVERT_EN
        inv = 1'b1;
        step();
        chk("inv idle level", o_strobe, 1'b1);
        seq("inv", 1, 3, 12, 14, 11, 14, 0, 0, 0, 17);
        $display("txn inv done total=%0d", total);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
